// File: rtl/bb_pkg.sv
// Shared definitions for the memory port arbiter: requester IDs, FSM encoding,
// default access timeout and the ordered-search helper used by the winner select.
package bb_pkg;

  localparam logic [1:0] REQ_F    = 2'd0;
  localparam logic [1:0] REQ_D    = 2'd1;
  localparam logic [1:0] REQ_IO   = 2'd2;
  localparam logic [1:0] REQ_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_DEFAULT = 15;

  // Returns the first requester of the search order p0, p1, p2 that is asserting req.
  function automatic logic [1:0] first_of(input logic [2:0] req,
                                          input logic [1:0] p0,
                                          input logic [1:0] p1,
                                          input logic [1:0] p2);
    logic [3:0] r;
    r = {1'b0, req};
    if (r[p0]) return p0;
    if (r[p1]) return p1;
    if (r[p2]) return p2;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/arb_pick_3.sv
// Combinational winner select among fetch/data/I/O requests.
// BB_ARB_RR_EN selects round-robin from a last-served pointer; otherwise fixed priority data > fetch > I/O.
module arb_pick_3
  import bb_pkg::*;
(
  input  logic [2:0] req,
`ifdef BB_ARB_RR_EN
  input  logic [1:0] last,
`endif
  output logic [1:0] grant,
  output logic       valid
);

  assign valid = |req;

`ifdef BB_ARB_RR_EN
  // Search starts one past the requester served last: fetch -> data -> I/O -> fetch.
  always_comb begin
    grant = REQ_NONE;
    case (last)
      REQ_F:   grant = first_of(req, REQ_D,  REQ_IO, REQ_F);
      REQ_D:   grant = first_of(req, REQ_IO, REQ_F,  REQ_D);
      default: grant = first_of(req, REQ_F,  REQ_D,  REQ_IO);
    endcase
  end
`else
  always_comb begin
    grant = first_of(req, REQ_D, REQ_F, REQ_IO);
  end
`endif

endmodule

// File: rtl/mem_arbiter_8bit.sv
// Serialises fetch, data and I/O accesses onto one 8-bit memory port with a req/ack handshake and wait timeout.
// Optional macro BB_ARB_RR_EN: round-robin arbitration instead of fixed data > fetch > I/O priority.
//   state  | meaning
//   IDLE   | no access; arbitrate pending requests
//   ACCESS | memory strobe driven, waiting for mem_ready or timeout
//   RESP   | ack (and err) pulse issued to the owner on leaving this state
module mem_arbiter_8bit
  import bb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_f,
  input  logic       req_d,
  input  logic       req_io,
  input  logic [7:0] addr_f,
  input  logic [7:0] addr_d,
  input  logic [7:0] addr_io,
  input  logic       we_d,
  input  logic       we_io,
  input  logic [7:0] wdata_d,
  input  logic [7:0] wdata_io,
  output logic       ack_f,
  output logic       ack_d,
  output logic       ack_io,
  output logic       err,
  output logic [7:0] rdata,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  output logic       busy,
  output logic [1:0] owner
);

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  arb_state_t state, state_nx;
  logic [7:0] wait_cnt;
  logic       err_flag;
  logic [2:0] req_vec;
  logic [1:0] pick;
  logic       pick_valid;
  logic       timeout_hit;
  logic       access_done;

  assign req_vec     = {req_io, req_d, req_f};
  assign timeout_hit = ({1'b0, wait_cnt} + 9'd1) >= TIMEOUT_LIM;
  assign access_done = (state == ST_ACCESS) && (mem_ready || timeout_hit);

`ifdef BB_ARB_RR_EN
  logic [1:0] last_served;

  arb_pick_3 u_pick (
    .req   (req_vec),
    .last  (last_served),
    .grant (pick),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_served <= REQ_IO;
    end else if (access_done) begin
      last_served <= owner;
    end
  end
`else
  arb_pick_3 u_pick (
    .req   (req_vec),
    .grant (pick),
    .valid (pick_valid)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (pick_valid) state_nx = ST_ACCESS;
      ST_ACCESS: if (mem_ready || timeout_hit) state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_f     <= 1'b0;
      ack_d     <= 1'b0;
      ack_io    <= 1'b0;
      err       <= 1'b0;
      err_flag  <= 1'b0;
      rdata     <= 8'h00;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 8'h00;
      busy      <= 1'b0;
      owner     <= REQ_NONE;
      wait_cnt  <= 8'h00;
    end else begin
      ack_f  <= 1'b0;
      ack_d  <= 1'b0;
      ack_io <= 1'b0;
      err    <= 1'b0;
      busy   <= (state_nx != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner    <= pick;
            mem_en   <= 1'b1;
            wait_cnt <= 8'h00;
            err_flag <= 1'b0;
            case (pick)
              REQ_F: begin
                mem_addr  <= addr_f;
                mem_we    <= 1'b0;
                mem_wdata <= 8'h00;
              end
              REQ_D: begin
                mem_addr  <= addr_d;
                mem_we    <= we_d;
                mem_wdata <= wdata_d;
              end
              default: begin
                mem_addr  <= addr_io;
                mem_we    <= we_io;
                mem_wdata <= wdata_io;
              end
            endcase
          end
        end
        ST_ACCESS: begin
          // A ready on the final allowed cycle still completes normally.
          if (mem_ready) begin
            rdata    <= mem_rdata;
            err_flag <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
          end else if (timeout_hit) begin
            rdata    <= 8'h00;
            err_flag <= 1'b1;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          err      <= err_flag;
          err_flag <= 1'b0;
          owner    <= REQ_NONE;
          case (owner)
            REQ_F:   ack_f  <= 1'b1;
            REQ_D:   ack_d  <= 1'b1;
            REQ_IO:  ack_io <= 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_8bit.sv
// Self-checking bench for mem_arbiter_8bit (TIMEOUT=4): directed scenarios plus randomized
// accesses checked against a transaction-level model of arbitration, latency and data.
module tb_mem_arbiter_8bit;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_f, req_d, req_io;
  logic [7:0] addr_f, addr_d, addr_io;
  logic       we_d, we_io;
  logic [7:0] wdata_d, wdata_io;
  logic       ack_f, ack_d, ack_io, err;
  logic [7:0] rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ready;
  logic       busy;
  logic [1:0] owner;

  int         vectors = 0;
  int         miscompares = 0;
  int         mem_wait = 255;
  logic [7:0] mem_val = 8'h00;
  bit         stray = 1'b0;
  int         acc_cyc = 0;
`ifdef BB_ARB_RR_EN
  int         model_last = 2;
`endif

  always #5 clk = ~clk;

  mem_arbiter_8bit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_f(req_f), .req_d(req_d), .req_io(req_io),
    .addr_f(addr_f), .addr_d(addr_d), .addr_io(addr_io),
    .we_d(we_d), .we_io(we_io), .wdata_d(wdata_d), .wdata_io(wdata_io),
    .ack_f(ack_f), .ack_d(ack_d), .ack_io(ack_io), .err(err), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .owner(owner)
  );

  // Memory: answers on ACCESS cycle mem_wait+1; optional stray ready pulses while idle.
  initial begin : mem_model
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        acc_cyc++;
        mem_ready = (acc_cyc == mem_wait + 1);
        mem_rdata = mem_ready ? mem_val : 8'($urandom);
      end else begin
        acc_cyc   = 0;
        mem_ready = stray ? 1'($urandom) : 1'b0;
        mem_rdata = 8'($urandom);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: winner ID for request bits {io, d, f}.
  function automatic int model_pick(input logic [2:0] r);
    int order[3];
`ifdef BB_ARB_RR_EN
    for (int i = 0; i < 3; i++) order[i] = (model_last + 1 + i) % 3;
`else
    order = '{1, 0, 2};
`endif
    for (int i = 0; i < 3; i++) if (r[order[i]]) return order[i];
    return 3;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req_f = 0; req_d = 0; req_io = 0;
    addr_f = 0; addr_d = 0; addr_io = 0;
    we_d = 0; we_io = 0; wdata_d = 0; wdata_io = 0;
    repeat (2) tick();
    vectors++;
    if ({ack_f, ack_d, ack_io, err, mem_en, mem_we, busy, owner} !== 9'b0000000_11) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected %b", {ack_f, ack_d, ack_io, err, mem_en, mem_we, busy, owner}, 9'b0000000_11);
    end
    vectors++;
    if ({rdata, mem_addr, mem_wdata} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected %h", {rdata, mem_addr, mem_wdata}, 24'h0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    mem_wait = 0; mem_val = 8'hA5;
    addr_f = 8'h10; req_f = 1;
    tick();
    vectors++;
    if (mem_en !== 1 || busy !== 1 || owner !== 2'd0 || mem_addr !== 8'h10 || mem_we !== 0) begin
      miscompares++;
      $display("FAIL fetch_grant: got en=%b busy=%b owner=%0d addr=%h we=%b expected en=1 busy=1 owner=0 addr=10 we=0",
               mem_en, busy, owner, mem_addr, mem_we);
    end
    tick();
    vectors++;
    if (ack_f !== 0) begin
      miscompares++;
      $display("FAIL fetch_early_ack: got %b expected 0", ack_f);
    end
    tick();
    vectors++;
    if (ack_f !== 1 || rdata !== 8'hA5 || err !== 0) begin
      miscompares++;
      $display("FAIL fetch_ack: got ack=%b rdata=%h err=%b expected ack=1 rdata=a5 err=0", ack_f, rdata, err);
    end
    req_f = 0;
    tick();
    vectors++;
    if (ack_f !== 0 || busy !== 0) begin
      miscompares++;
      $display("FAIL fetch_after: got ack=%b busy=%b expected 0 0", ack_f, busy);
    end
  endtask

  task automatic test_data_write();
    mem_wait = 3; mem_val = 8'h11;
    req_d = 1; addr_d = 8'h80; we_d = 1; wdata_d = 8'h3C;
    for (int c = 1; c <= 4; c++) begin
      tick();
      vectors++;
      if (mem_en !== 1 || mem_we !== 1 || mem_wdata !== 8'h3C || mem_addr !== 8'h80 || ack_d !== 0) begin
        miscompares++;
        $display("FAIL write_hold_%0d: got en=%b we=%b wdata=%h addr=%h ack=%b expected 1 1 3c 80 0",
                 c, mem_en, mem_we, mem_wdata, mem_addr, ack_d);
      end
    end
    tick();
    vectors++;
    if (mem_en !== 0 || ack_d !== 0) begin
      miscompares++;
      $display("FAIL write_resp: got en=%b ack=%b expected 0 0", mem_en, ack_d);
    end
    tick();
    vectors++;
    if (ack_d !== 1 || err !== 0) begin
      miscompares++;
      $display("FAIL write_ack: got ack=%b err=%b expected 1 0", ack_d, err);
    end
    req_d = 0; we_d = 0;
    tick();
  endtask

  task automatic test_simultaneous();
    int exp_owner[4];
`ifdef BB_ARB_RR_EN
    exp_owner = '{0, 1, 2, 0};
`else
    exp_owner = '{1, 1, 1, 1};
`endif
    rst = 1; tick(); rst = 0;
    mem_wait = 0; mem_val = 8'h5A;
    addr_f = 8'h01; addr_d = 8'h02; addr_io = 8'h03; we_d = 0; we_io = 0;
    req_f = 1; req_d = 1; req_io = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (owner !== 2'(exp_owner[i])) begin
        miscompares++;
        $display("FAIL simul_owner_%0d: got %0d expected %0d", i, owner, exp_owner[i]);
      end
      tick();
      tick();
      vectors++;
      if ({ack_f, ack_d, ack_io} !== 3'(3'b100 >> exp_owner[i])) begin
        miscompares++;
        $display("FAIL simul_ack_%0d: got %b expected %b", i, {ack_f, ack_d, ack_io}, 3'(3'b100 >> exp_owner[i]));
      end
    end
    req_f = 0; req_d = 0; req_io = 0;
    tick();
  endtask

  task automatic test_timeout();
    mem_wait = 255;
    req_io = 1; addr_io = 8'h44; we_io = 0;
    tick();
    vectors++;
    if (owner !== 2'd2 || mem_addr !== 8'h44) begin
      miscompares++;
      $display("FAIL timeout_grant: got owner=%0d addr=%h expected 2 44", owner, mem_addr);
    end
    for (int c = 1; c <= TO; c++) begin
      tick();
      vectors++;
      if (ack_io !== 0) begin
        miscompares++;
        $display("FAIL timeout_early_%0d: got ack=%b expected 0", c, ack_io);
      end
    end
    tick();
    vectors++;
    if (ack_io !== 1 || err !== 1 || rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL timeout_ack: got ack=%b err=%b rdata=%h expected 1 1 00", ack_io, err, rdata);
    end
    req_io = 0;
    tick();
    vectors++;
    if (err !== 0) begin
      miscompares++;
      $display("FAIL timeout_err_clear: got %b expected 0", err);
    end
  endtask

  task automatic test_reset_mid();
    mem_wait = 255;
    req_d = 1; addr_d = 8'h22; we_d = 1; wdata_d = 8'h99;
    tick();
    vectors++;
    if (mem_en !== 1 || owner !== 2'd1) begin
      miscompares++;
      $display("FAIL rstmid_grant: got en=%b owner=%0d expected 1 1", mem_en, owner);
    end
    tick();
    #2 rst = 1;
    #1;
    vectors++;
    if (mem_en !== 0 || owner !== 2'd3 || busy !== 0) begin
      miscompares++;
      $display("FAIL rstmid_async: got en=%b owner=%0d busy=%b expected 0 3 0", mem_en, owner, busy);
    end
    req_d = 0; we_d = 0; req_f = 1; addr_f = 8'h31; mem_wait = 1; mem_val = 8'h77;
    tick();
    vectors++;
    if ({ack_f, ack_d, ack_io} !== 3'b000) begin
      miscompares++;
      $display("FAIL rstmid_noack: got %b expected 000", {ack_f, ack_d, ack_io});
    end
    rst = 0;
    tick();
    vectors++;
    if (owner !== 2'd0 || mem_addr !== 8'h31 || {ack_f, ack_d, ack_io} !== 3'b000) begin
      miscompares++;
      $display("FAIL rstmid_regrant: got owner=%0d addr=%h acks=%b expected 0 31 000", owner, mem_addr, {ack_f, ack_d, ack_io});
    end
    repeat (3) tick();
    vectors++;
    if (ack_f !== 1 || rdata !== 8'h77 || err !== 0) begin
      miscompares++;
      $display("FAIL rstmid_ack: got ack=%b rdata=%h err=%b expected 1 77 0", ack_f, rdata, err);
    end
    req_f = 0;
    tick();
  endtask

  task automatic test_drop_payload();
    int lat;
    bit got;
    mem_wait = 2; mem_val = 8'hC3;
    req_d = 1; addr_d = 8'h90; we_d = 0;
    tick();
    req_d = 0; addr_d = 8'hFF;
    tick();
    vectors++;
    if (mem_addr !== 8'h90 || mem_en !== 1) begin
      miscompares++;
      $display("FAIL drop_addr: got addr=%h en=%b expected 90 1", mem_addr, mem_en);
    end
    lat = 1; got = 0;
    for (int c = 2; c <= 10 && !got; c++) begin
      tick();
      if (ack_d) begin got = 1; lat = c; end
    end
    vectors++;
    if (!got || lat != 4 || rdata !== 8'hC3) begin
      miscompares++;
      $display("FAIL drop_ack: got seen=%0d latency=%0d rdata=%h expected 1 4 c3", got, lat, rdata);
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    logic [7:0] a[3];
    logic       w[3];
    logic [7:0] wd[3];
    logic [7:0] val;
    logic       exp_err;
    int         e, k, lat, wt;
    bit         got;
    rst = 1; tick(); rst = 0;
`ifdef BB_ARB_RR_EN
    model_last = 2;
`endif
    stray = 1;
    for (int it = 0; it < 40; it++) begin
      r = 3'($urandom_range(1, 7));
      for (int j = 0; j < 3; j++) begin
        a[j] = 8'($urandom); w[j] = 1'($urandom); wd[j] = 8'($urandom);
      end
      wt = $urandom_range(0, 5);
      val = 8'($urandom);
      mem_wait = wt; mem_val = val;
      req_f = r[0]; req_d = r[1]; req_io = r[2];
      addr_f = a[0]; addr_d = a[1]; addr_io = a[2];
      we_d = w[1]; we_io = w[2]; wdata_d = wd[1]; wdata_io = wd[2];
      e = model_pick(r);
      tick();
      vectors++;
      if (owner !== 2'(e) || mem_en !== 1 || mem_addr !== a[e] || mem_we !== (e == 0 ? 1'b0 : w[e])) begin
        miscompares++;
        $display("FAIL rand_grant_%0d: got owner=%0d en=%b addr=%h we=%b expected %0d 1 %h %b",
                 it, owner, mem_en, mem_addr, mem_we, e, a[e], (e == 0 ? 1'b0 : w[e]));
      end
      if (e != 0 && w[e]) begin
        vectors++;
        if (mem_wdata !== wd[e]) begin
          miscompares++;
          $display("FAIL rand_wdata_%0d: got %h expected %h", it, mem_wdata, wd[e]);
        end
      end
      k = (wt + 1 < TO) ? wt + 1 : TO;
      exp_err = (wt + 1 > TO);
      lat = 0; got = 0;
      for (int c = 1; c <= 12 && !got; c++) begin
        tick();
        if (ack_f | ack_d | ack_io) begin got = 1; lat = c; end
      end
      vectors++;
      if (!got || lat != k + 1 || {ack_f, ack_d, ack_io} !== 3'(3'b100 >> e)) begin
        miscompares++;
        $display("FAIL rand_ack_%0d: got seen=%0d latency=%0d acks=%b expected 1 %0d %b",
                 it, got, lat, {ack_f, ack_d, ack_io}, k + 1, 3'(3'b100 >> e));
      end
      vectors++;
      if (err !== exp_err || rdata !== (exp_err ? 8'h00 : val)) begin
        miscompares++;
        $display("FAIL rand_data_%0d: got err=%b rdata=%h expected %b %h",
                 it, err, rdata, exp_err, (exp_err ? 8'h00 : val));
      end
`ifdef BB_ARB_RR_EN
      model_last = e;
`endif
      req_f = 0; req_d = 0; req_io = 0;
    end
    stray = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_write();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    test_drop_payload();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
